// File: rtl/pipe_pkg.sv
// Shared types for the skid-buffered pipeline stage.
package pipe_pkg;

  // Occupancy of the stage: no beat, one beat in main, beats in main and skid.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_BUSY  = 2'd1,
    ST_FULL  = 2'd2
  } skid_state_t;

endpackage

// File: rtl/pipe_stage_skid_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_clr,
  input  logic         i_inc,
  output logic [W-1:0] o_cnt
);

  localparam logic [W-1:0] CNT_MAX = {W{1'b1}};
  localparam logic [W-1:0] CNT_ONE = {{(W-1){1'b0}}, 1'b1};

  // Count qualifying cycles, holding at all-ones instead of wrapping.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_cnt <= '0;
    end else if (i_clr) begin
      o_cnt <= '0;
    end else if (i_inc && (o_cnt != CNT_MAX)) begin
      o_cnt <= o_cnt + CNT_ONE;
    end
  end

endmodule

// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with a 2-entry skid buffer, registered ready,
// flush-to-bubble and saturating stall/bubble counters.
//
// Handshake: a beat moves upstream->stage when i_valid & o_ready on a rising
// edge, and stage->downstream when o_valid & i_ready. A valid beat stays
// stable until taken; o_ready is a register, so there is no path from
// i_ready to o_ready. The skid entry always holds the younger beat.
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int CTRL_W     = 11,
  parameter bit CLEAR_DATA = 1'b1,
  parameter int CNT_W      = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_flush,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [DATA_W-1:0] i_data,
  input  logic [CTRL_W-1:0] i_ctrl,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [DATA_W-1:0] o_data,
  output logic [CTRL_W-1:0] o_ctrl,
  input  logic              i_cnt_clr,
  output logic [CNT_W-1:0]  o_stall_cnt,
  output logic [CNT_W-1:0]  o_bubble_cnt,
  output skid_state_t       o_dbg_state
);

  skid_state_t       state;
  logic              ready_q;
  logic [DATA_W-1:0] main_data;
  logic [CTRL_W-1:0] main_ctrl;
  logic [DATA_W-1:0] skid_data;
  logic [CTRL_W-1:0] skid_ctrl;
  logic              acc;
  logic              take;

  assign acc         = i_valid & ready_q;
  assign take        = o_valid & i_ready;
  assign o_valid     = (state != ST_EMPTY);
  assign o_ready     = ready_q;
  assign o_data      = main_data;
  assign o_ctrl      = main_ctrl;
  assign o_dbg_state = state;

  // Occupancy FSM; ready_q is low only while both entries are held.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state   <= ST_EMPTY;
      ready_q <= 1'b1;
    end else if (i_flush) begin
      state   <= ST_EMPTY;
      ready_q <= 1'b1;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (acc) state <= ST_BUSY;
          ready_q <= 1'b1;
        end
        ST_BUSY: begin
          if (acc && !take) begin
            state   <= ST_FULL;
            ready_q <= 1'b0;
          end else if (!acc && take) begin
            state   <= ST_EMPTY;
            ready_q <= 1'b1;
          end
        end
        ST_FULL: begin
          if (take) begin
            state   <= ST_BUSY;
            ready_q <= 1'b1;
          end
        end
        default: begin
          state   <= ST_EMPTY;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  // Main register: the beat presented downstream; cleaned to a bubble when emptied.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      main_data <= '0;
      main_ctrl <= '0;
    end else if (i_flush) begin
      main_ctrl <= '0;
      if (CLEAR_DATA) main_data <= '0;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (acc) begin
            main_data <= i_data;
            main_ctrl <= i_ctrl;
          end
        end
        ST_BUSY: begin
          if (acc && take) begin
            main_data <= i_data;
            main_ctrl <= i_ctrl;
          end else if (!acc && take) begin
            main_ctrl <= '0;
            if (CLEAR_DATA) main_data <= '0;
          end
        end
        ST_FULL: begin
          if (take) begin
            main_data <= skid_data;
            main_ctrl <= skid_ctrl;
          end
        end
        default: begin
          main_ctrl <= '0;
        end
      endcase
    end
  end

  // Skid register: catches the beat accepted while downstream stalls.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      skid_data <= '0;
      skid_ctrl <= '0;
    end else if (i_flush) begin
      skid_ctrl <= '0;
      if (CLEAR_DATA) skid_data <= '0;
    end else if ((state == ST_BUSY) && acc && !take) begin
      skid_data <= i_data;
      skid_ctrl <= i_ctrl;
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_clr (i_cnt_clr),
    .i_inc (o_valid & ~i_ready),
    .o_cnt (o_stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_bubble_cnt (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_clr (i_cnt_clr),
    .i_inc (~o_valid & i_ready),
    .o_cnt (o_bubble_cnt)
  );

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: two instances (clearing/16-bit counters and
// stale-data/4-bit counters) share one stimulus stream and are compared
// every cycle against a FIFO-occupancy model.
module tb_pipe_stage_skid;
  import pipe_pkg::*;

  localparam int DW = 32;
  localparam int CW = 11;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          i_flush = 1'b0;
  logic          i_valid = 1'b0;
  logic          i_ready = 1'b0;
  logic [DW-1:0] i_data  = '0;
  logic [CW-1:0] i_ctrl  = '0;
  logic          i_cnt_clr = 1'b0;

  logic          a_ready, a_valid, b_ready, b_valid;
  logic [DW-1:0] a_data, b_data;
  logic [CW-1:0] a_ctrl, b_ctrl;
  logic [15:0]   a_stall, a_bubble;
  logic [3:0]    b_stall, b_bubble;
  skid_state_t   a_state, b_state;

  pipe_stage_skid #(.DATA_W(DW), .CTRL_W(CW), .CLEAR_DATA(1'b1), .CNT_W(16)) dut_a (
    .i_clk(clk), .i_rst(rst), .i_flush(i_flush), .i_valid(i_valid), .o_ready(a_ready),
    .i_data(i_data), .i_ctrl(i_ctrl), .o_valid(a_valid), .i_ready(i_ready),
    .o_data(a_data), .o_ctrl(a_ctrl), .i_cnt_clr(i_cnt_clr),
    .o_stall_cnt(a_stall), .o_bubble_cnt(a_bubble), .o_dbg_state(a_state)
  );

  pipe_stage_skid #(.DATA_W(DW), .CTRL_W(CW), .CLEAR_DATA(1'b0), .CNT_W(4)) dut_b (
    .i_clk(clk), .i_rst(rst), .i_flush(i_flush), .i_valid(i_valid), .o_ready(b_ready),
    .i_data(i_data), .i_ctrl(i_ctrl), .o_valid(b_valid), .i_ready(i_ready),
    .o_data(b_data), .o_ctrl(b_ctrl), .i_cnt_clr(i_cnt_clr),
    .o_stall_cnt(b_stall), .o_bubble_cnt(b_bubble), .o_dbg_state(b_state)
  );

  // ---------------- scoreboard counts ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  // Stage = FIFO of depth 2 holding {ctrl,data}; head is what is shown.
  logic [CW+DW-1:0] exp_q[$];
  logic [DW-1:0]    last_head = '0;
  logic             m_ready   = 1'b1;
  int unsigned      st_a = 0, bu_a = 0, st_b = 0, bu_b = 0;

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        exp_q.delete();
        last_head = '0;
        m_ready   = 1'b1;
        st_a = 0; bu_a = 0; st_b = 0; bu_b = 0;
      end else begin
        bit m_valid, m_acc, m_take;
        m_valid = (exp_q.size() > 0);
        m_acc   = i_valid && m_ready;
        m_take  = m_valid && i_ready;
        if (i_cnt_clr) begin
          st_a = 0; bu_a = 0; st_b = 0; bu_b = 0;
        end else begin
          if (m_valid && !i_ready) begin
            if (st_a < 65535) st_a++;
            if (st_b < 15) st_b++;
          end
          if (!m_valid && i_ready) begin
            if (bu_a < 65535) bu_a++;
            if (bu_b < 15) bu_b++;
          end
        end
        if (i_flush) begin
          if (m_valid) last_head = exp_q[0][DW-1:0];
          exp_q.delete();
        end else begin
          if (m_take) begin
            last_head = exp_q[0][DW-1:0];
            void'(exp_q.pop_front());
          end
          if (m_acc) exp_q.push_back({i_ctrl, i_data});
        end
        m_ready = (exp_q.size() < 2);
      end
    end
  end

  // Compare both instances against the model on every falling edge.
  initial begin
    forever begin
      logic          ev;
      logic [CW-1:0] ectrl;
      logic [DW-1:0] eda, edb;
      @(negedge clk);
      ev    = (exp_q.size() > 0);
      ectrl = ev ? exp_q[0][CW+DW-1:DW] : '0;
      eda   = ev ? exp_q[0][DW-1:0] : '0;
      edb   = ev ? exp_q[0][DW-1:0] : last_head;
      check("a_valid",  a_valid,  ev);
      check("b_valid",  b_valid,  ev);
      check("a_ready",  a_ready,  m_ready);
      check("b_ready",  b_ready,  m_ready);
      check("a_ctrl",   a_ctrl,   ectrl);
      check("b_ctrl",   b_ctrl,   ectrl);
      check("a_data",   a_data,   eda);
      check("b_data",   b_data,   edb);
      check("a_stall",  a_stall,  st_a);
      check("b_stall",  b_stall,  st_b);
      check("a_bubble", a_bubble, bu_a);
      check("b_bubble", b_bubble, bu_b);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic r, input logic f, input logic c,
                       input logic [DW-1:0] d);
    i_valid   = v;
    i_ready   = r;
    i_flush   = f;
    i_cnt_clr = c;
    i_data    = d;
    i_ctrl    = d[CW-1:0] | 11'h400;
  endtask

  task automatic drain(input int n);
    drive(1'b0, 1'b1, 1'b0, 1'b0, '0);
    for (int i = 0; i < n; i++) step();
  endtask

  // Assert reset between edges and check outputs before the next edge.
  task automatic async_reset(input string tag);
    drive(1'b0, 1'b0, 1'b0, 1'b0, '0);
    #2 rst = 1'b1;
    #1;
    check({tag, "_rst_valid"}, a_valid, 1'b0);
    check({tag, "_rst_ready"}, a_ready, 1'b1);
    check({tag, "_rst_ctrl"},  a_ctrl,  '0);
    check({tag, "_rst_stall"}, a_stall, '0);
    check({tag, "_rst_bubble"}, a_bubble, '0);
    check({tag, "_rst_bdata"}, b_data, '0);
    @(posedge clk);
    #3 rst = 1'b0;
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #3 rst = 1'b0;
    step();

    // Streaming 1..8, full throughput.
    drain(2);
    for (int k = 1; k <= 8; k++) begin
      drive(1'b1, 1'b1, 1'b0, 1'b0, k);
      step();
      check("stream_data",  a_data,  k);
      check("stream_valid", a_valid, 1'b1);
      check("stream_ready", a_ready, 1'b1);
    end
    drive(1'b0, 1'b1, 1'b0, 1'b0, '0);
    step();
    check("stream_end_valid", a_valid, 1'b0);
    check("stream_end_ctrl",  a_ctrl,  '0);

    // Backpressure: A,B accepted, C held upstream while FULL.
    drain(2);
    drive(1'b1, 1'b0, 1'b0, 1'b1, 32'hA);
    step();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'hB);
    step();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'hC);
    for (int i = 0; i < 3; i++) begin
      step();
      check("bp_ready_low", a_ready, 1'b0);
      check("bp_state_full", a_state, ST_FULL);
      check("bp_hold_a", a_data, 32'hA);
    end
    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'hC);
    check("bp_stall_cnt", a_stall, 16'd4);
    step();
    check("bp_order_b", a_data, 32'hB);
    step();
    check("bp_order_c", a_data, 32'hC);
    drive(1'b0, 1'b1, 1'b0, 1'b0, '0);
    step();
    check("bp_drained", a_valid, 1'b0);

    // Flush in FULL with a concurrent beat D.
    drain(2);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'hA0);
    step();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'hB0);
    step();
    drive(1'b1, 1'b0, 1'b1, 1'b0, 32'hD0);
    step();
    check("fl_a_valid", a_valid, 1'b0);
    check("fl_a_ctrl",  a_ctrl,  '0);
    check("fl_a_data",  a_data,  '0);
    check("fl_b_valid", b_valid, 1'b0);
    check("fl_b_ctrl",  b_ctrl,  '0);
    check("fl_b_data",  b_data,  32'hA0);
    check("fl_ready",   a_ready, 1'b1);
    drive(1'b0, 1'b1, 1'b0, 1'b0, '0);
    step();
    check("fl_no_d", a_valid, 1'b0);
    check("fl_b_stale", b_data, 32'hA0);

    // Counter saturation on the 4-bit instance, then clear.
    drain(1);
    drive(1'b1, 1'b0, 1'b0, 1'b1, 32'h55);
    step();
    drive(1'b0, 1'b0, 1'b0, 1'b0, '0);
    for (int i = 0; i < 20; i++) step();
    check("sat_b_stall", b_stall, 4'd15);
    check("sat_a_stall", a_stall, 16'd20);
    drive(1'b0, 1'b0, 1'b0, 1'b1, '0);
    step();
    check("clr_b_stall", b_stall, 4'd0);
    check("clr_a_stall", a_stall, 16'd0);
    drain(2);

    // Randomised traffic with a reset landing mid-transfer.
    for (int i = 0; i < 1500; i++) begin
      if (i == 700) begin
        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h77);
        step();
        async_reset("mid");
      end
      drive($urandom_range(0, 99) < 70, $urandom_range(0, 99) < 60,
            $urandom_range(0, 99) < 3,  $urandom_range(0, 99) < 2, $urandom);
      i_ctrl = CW'($urandom);
      step();
    end

    async_reset("end");
    step();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
